fib_core_arbiter: RTL and testbench

//  Shares one fibonacci index core among NUM_REQ requesters.
//  - Arbitration is round-robin.
//  - One job is in flight at a time.
//  - Each result is routed back to the requester that issued the job.
//  - A watchdog returns an error if the core does not answer.

---
 rtl/fib_arb_pkg.sv | 24 ++
 rtl/fib_core_arbiter_rr_arbiter.sv | 28 ++
 rtl/fib_core_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fib_core_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_arb_pkg.sv
// Shared types and constants for the fibonacci core arbiter.
package fib_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 64;
   localparam int TIMEOUT_DEF = 256;
   localparam int ID_W        = $clog2(NUM_REQ_DEF);

   // Result reported when the number is not fibonacci or the core timed out.
   localparam logic signed [DATA_W_DEF-1:0] INDEX_NONE = -64'sd1;

   // Width of a requester id; never below one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fib_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i (wrapping).
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] gnt_id_o,
   output logic           any_o
);

   // Scan ptr+1, ptr+2, ... modulo N and keep the first active request.
   always_comb begin
      int idx;
      gnt_id_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (req_i[idx] && !any_o) begin
            gnt_id_o = IDW'(idx);
            any_o    = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/fib_core_arbiter.sv
// Shares one fibonacci index core among NUM_REQ requesters, one job at a
// time, with round-robin grants, result routing and a response watchdog.
module fib_core_arbiter
   import fib_arb_pkg::*;
#(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_number_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [NUM_REQ-1:0]          resp_valid_o,
   output logic signed [DATA_W-1:0]    resp_index_o,
   output logic                        resp_err_o,
   output logic                        busy_o,
   output logic [DATA_W-1:0]           core_number_o,
   output logic                        core_valid_o,
   input  logic                        core_ready_i,
   input  logic signed [DATA_W-1:0]    core_index_i,
   input  logic                        core_index_valid_i
);

   localparam int REQ_ID_W = id_width(NUM_REQ);
   localparam int WD_W     = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic signed [DATA_W-1:0] IDX_NONE = DATA_W'(INDEX_NONE);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_e            state_q, state_d;
   logic [REQ_ID_W-1:0]   id_q, id_d;
   logic [REQ_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
   logic signed [DATA_W-1:0] resp_index_q, resp_index_d;
   logic                  resp_err_q, resp_err_d;
   logic                  busy_q, busy_d;
   logic [DATA_W-1:0]     core_number_q, core_number_d;
   logic                  core_valid_q, core_valid_d;

   logic [REQ_ID_W-1:0]   arb_id_s;
   logic                  arb_any_s;

   rr_arbiter #(
      .N   (NUM_REQ),
      .IDW (REQ_ID_W)
   ) u_rr (
      .req_i    (req_valid_i),
      .ptr_i    (rr_ptr_q),
      .gnt_id_o (arb_id_s),
      .any_o    (arb_any_s)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: grant only while the core can take a job.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (arb_any_s && core_ready_i) state_d = ISSUE;
            else                           state_d = IDLE;
         end
         ISSUE: begin
            if (core_ready_i) state_d = WAIT;
            else              state_d = ISSUE;
         end
         WAIT: begin
            if (core_index_valid_i)   state_d = RESP;
            else if (wd_q == WD_LAST) state_d = RESP;
            else                      state_d = WAIT;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; pulses default low, data holds.
   always_comb begin
      id_d          = id_q;
      rr_ptr_d      = rr_ptr_q;
      wd_d          = wd_q;
      req_ready_d   = '0;
      resp_valid_d  = '0;
      resp_index_d  = resp_index_q;
      resp_err_d    = resp_err_q;
      core_number_d = core_number_q;
      core_valid_d  = 1'b0;
      busy_d        = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (state_d == ISSUE) begin
               id_d          = arb_id_s;
               core_number_d = req_number_i[arb_id_s*DATA_W +: DATA_W];
               req_ready_d   = ONE_HOT0 << arb_id_s;
               core_valid_d  = 1'b1;
            end else begin
               core_valid_d  = 1'b0;
            end
         end
         ISSUE: begin
            if (state_d == WAIT) begin
               wd_d         = '0;
               core_valid_d = 1'b0;
            end else begin
               core_valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (core_index_valid_i) begin
               resp_index_d = core_index_i;
               resp_err_d   = 1'b0;
               resp_valid_d = ONE_HOT0 << id_q;
            end else if (wd_q == WD_LAST) begin
               resp_index_d = IDX_NONE;
               resp_err_d   = 1'b1;
               resp_valid_d = ONE_HOT0 << id_q;
            end else begin
               wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            rr_ptr_d = id_q;
         end
         default: begin
            rr_ptr_d = rr_ptr_q;
         end
      endcase
   end

   // Registered outputs, job latches, pointer and watchdog.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_q          <= '0;
         rr_ptr_q      <= REQ_ID_W'(NUM_REQ - 1);
         wd_q          <= '0;
         req_ready_q   <= '0;
         resp_valid_q  <= '0;
         resp_index_q  <= '0;
         resp_err_q    <= 1'b0;
         busy_q        <= 1'b0;
         core_number_q <= '0;
         core_valid_q  <= 1'b0;
      end else begin
         id_q          <= id_d;
         rr_ptr_q      <= rr_ptr_d;
         wd_q          <= wd_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_index_q  <= resp_index_d;
         resp_err_q    <= resp_err_d;
         busy_q        <= busy_d;
         core_number_q <= core_number_d;
         core_valid_q  <= core_valid_d;
      end
   end

   assign req_ready_o   = req_ready_q;
   assign resp_valid_o  = resp_valid_q;
   assign resp_index_o  = resp_index_q;
   assign resp_err_o    = resp_err_q;
   assign busy_o        = busy_q;
   assign core_number_o = core_number_q;
   assign core_valid_o  = core_valid_q;

endmodule

// File: tb/tb_fib_core_arbiter.sv
// Directed bench for fib_core_arbiter: table of single jobs plus
// hand-written sequences for arbitration order, reset, spurious results
// and core back-pressure.
module tb_fib_core_arbiter;

   localparam int NR = 4;
   localparam int DW = 64;

   logic                 clk;
   logic                 rst;
   logic [NR-1:0]        req_valid;
   logic [NR*DW-1:0]     req_number;
   logic [NR-1:0]        req_ready;
   logic [NR-1:0]        resp_valid;
   logic signed [DW-1:0] resp_index;
   logic                 resp_err;
   logic                 busy;
   logic [DW-1:0]        core_number;
   logic                 core_valid;
   logic                 core_ready;
   logic signed [DW-1:0] core_index;
   logic                 civ;

   int tests;
   int fails;

   fib_core_arbiter #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (req_valid),
      .req_number_i       (req_number),
      .req_ready_o        (req_ready),
      .resp_valid_o       (resp_valid),
      .resp_index_o       (resp_index),
      .resp_err_o         (resp_err),
      .busy_o             (busy),
      .core_number_o      (core_number),
      .core_valid_o       (core_valid),
      .core_ready_i       (core_ready),
      .core_index_i       (core_index),
      .core_index_valid_i (civ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int                   r;
      logic [DW-1:0]        num;
      logic signed [DW-1:0] ans;
      int                   lat;      // WAIT cycle of core answer, -1 = never
      logic signed [DW-1:0] exp_idx;
      logic                 exp_err;
      int                   exp_wait; // ticks from first WAIT cycle to resp
   } job_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v = 4'b0001;
      return v << i;
   endfunction

   task automatic run_job(input job_t j);
      int n;
      req_number[j.r*DW +: DW] = j.num;
      req_valid[j.r] = 1'b1;
      core_ready = 1'b1;
      n = 0;
      tick();
      while (req_ready == '0 && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready", req_ready, onehot(j.r));
      chk("core_valid", core_valid, 1);
      chk("core_number", core_number, j.num);
      req_valid[j.r] = 1'b0;
      tick();
      chk("core_valid_wait", core_valid, 0);
      chk("req_ready_pulse", req_ready, 0);
      n = 0;
      while (n < 40) begin
         if (n == j.lat) begin
            civ = 1'b1;
            core_index = j.ans;
         end
         tick();
         civ = 1'b0;
         n++;
         if (resp_valid != '0) break;
      end
      chk("resp_valid", resp_valid, onehot(j.r));
      chk("resp_index", resp_index, j.exp_idx);
      chk("resp_err", resp_err, j.exp_err);
      chk("wait_cycles", n, j.exp_wait);
      tick();
      chk("resp_pulse_end", resp_valid, 0);
      chk("busy_end", busy, 0);
      chk("resp_index_hold", resp_index, j.exp_idx);
   endtask

   job_t jobs[6];
   job_t j4;
   int   order[5];
   int   n;

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      req_valid = '0;
      req_number = '0;
      core_ready = 1'b1;
      core_index = '0;
      civ = 1'b0;

      jobs[0] = '{2, 64'd5,   64'sd5,  0,  64'sd5,  1'b0, 1};
      jobs[1] = '{0, 64'd89,  64'sd11, 2,  64'sd11, 1'b0, 3};
      jobs[2] = '{3, 64'd4,   -64'sd1, 5,  -64'sd1, 1'b0, 6};
      jobs[3] = '{1, 64'd0,   64'sd0,  0,  64'sd0,  1'b0, 1};
      jobs[4] = '{1, 64'd100, 64'sd0,  -1, -64'sd1, 1'b1, 16};
      jobs[5] = '{3, 64'd144, 64'sd12, 15, 64'sd12, 1'b0, 16};
      order = '{0, 1, 2, 3, 0};

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_index", resp_index, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_valid", core_valid, 0);
      chk("rst_core_number", core_number, 0);

      // All four requesting continuously: grants 0,1,2,3,0
      for (int i = 0; i < NR; i++) req_number[i*DW +: DW] = 64'(10 + i);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (req_ready == '0 && n < 20);
         chk("rr_grant", req_ready, onehot(order[k]));
         chk("rr_number", core_number, 64'(10 + order[k]));
         tick();
         civ = 1'b1;
         core_index = 64'(k + 1);
         tick();
         civ = 1'b0;
         chk("rr_resp_valid", resp_valid, onehot(order[k]));
         chk("rr_resp_index", resp_index, 64'(k + 1));
      end
      req_valid = '0;
      tick();

      // Reset while waiting on the core (last winner was 0)
      req_valid = 4'b0100;
      tick();
      chk("rstw_grant", req_ready, 4'b0100);
      req_valid = '0;
      tick();
      chk("rstw_busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstw_busy", busy, 0);
      chk("rstw_resp_valid", resp_valid, 0);
      chk("rstw_core_valid", core_valid, 0);
      civ = 1'b1;
      core_index = 64'sd55;
      tick();
      civ = 1'b0;
      chk("rstw_late_result", resp_valid, 0);
      req_valid = 4'b0011;
      tick();
      chk("rstw_next_grant", req_ready, 4'b0001);
      req_valid = '0;
      tick();
      civ = 1'b1;
      core_index = 64'sd7;
      tick();
      civ = 1'b0;
      chk("rstw_resp_valid2", resp_valid, 4'b0001);
      chk("rstw_resp_index2", resp_index, 7);
      tick();

      // Table of single jobs
      for (int i = 0; i < 6; i++) run_job(jobs[i]);

      // Spurious core result while idle, then a normal job
      civ = 1'b1;
      core_index = 64'sd77;
      tick();
      civ = 1'b0;
      chk("spur_resp0", resp_valid, 0);
      tick();
      chk("spur_resp1", resp_valid, 0);
      chk("spur_busy", busy, 0);
      chk("spur_index_kept", resp_index, 12);
      j4 = '{2, 64'd89, 64'sd11, 0, 64'sd11, 1'b0, 1};
      run_job(j4);

      // Core not ready while requester 1 waits, then stall in ISSUE
      core_ready = 1'b0;
      req_number[1*DW +: DW] = 64'd3;
      req_valid = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("cr_no_grant", req_ready, 0);
         chk("cr_not_busy", busy, 0);
      end
      core_ready = 1'b1;
      tick();
      chk("cr_grant", req_ready, 4'b0010);
      chk("cr_core_number", core_number, 3);
      req_valid = '0;
      core_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("cr_issue_hold", core_valid, 1);
         chk("cr_ready_once", req_ready, 0);
      end
      core_ready = 1'b1;
      tick();
      chk("cr_wait_core_valid", core_valid, 0);
      civ = 1'b1;
      core_index = 64'sd4;
      tick();
      civ = 1'b0;
      chk("cr_resp_valid", resp_valid, 4'b0010);
      chk("cr_resp_index", resp_index, 4);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
